// File: rtl/serial_ha_ctrl.sv
// Bit-serial adder built around a single time-shared half-adder: two phases per bit, LSB first.
// Optional carry-in port is enabled by defining SERIAL_HA_CIN_EN.
module serial_ha_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef SERIAL_HA_CIN_EN
  input  logic             cin,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int IDX_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    PH1,
    PH2,
    DONE
  } state_t;

  state_t           state;
  state_t           state_nxt;

  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_sr;
  logic [IDX_W-1:0] idx;
  logic             carry;
  logic             s1;
  logic             c1;

  logic             ha_x;
  logic             ha_y;
  logic             ha_s;
  logic             ha_c;
  logic             last_bit;
  logic             cin_load;
  logic [WIDTH-1:0] res_nxt;
  logic             carry_nxt;

`ifdef SERIAL_HA_CIN_EN
  assign cin_load = cin;
`else
  assign cin_load = 1'b0;
`endif

  assign last_bit  = (idx == IDX_W'(WIDTH - 1));
  assign res_nxt   = {ha_s, res_sr[WIDTH-1:1]};
  assign carry_nxt = c1 | ha_c;

  // The one and only adder cell; its operands are steered by the phase.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    ha_x = 1'b0;
    ha_y = 1'b0;
    case (state)
      PH1: begin
        ha_x = a_sr[0];
        ha_y = b_sr[0];
      end
      PH2: begin
        ha_x = s1;
        ha_y = carry;
      end
      default: ;
    endcase
    ha_s = ha_x ^ ha_y;
    ha_c = ha_x & ha_y;
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b1;
    done      = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = PH1;
      end
      PH1:  state_nxt = PH2;
      PH2:  state_nxt = last_bit ? DONE : PH1;
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: a reset mid-operation must discard everything, so every datapath register is cleared, not just the FSM.
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      idx    <= '0;
      carry  <= 1'b0;
      s1     <= 1'b0;
      c1     <= 1'b0;
      sum    <= '0;
      cout   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sr   <= a;
            b_sr   <= b;
            res_sr <= '0;
            carry  <= cin_load;
            idx    <= '0;
          end
        end
        PH1: begin
          s1 <= ha_s;
          c1 <= ha_c;
        end
        PH2: begin
          res_sr <= res_nxt;
          carry  <= carry_nxt;
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          // Outputs are only published once the final bit is in, never partially.
          if (last_bit) begin
            sum  <= res_nxt;
            cout <= carry_nxt;
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
